// File: rtl/hazard_pc_controller.sv
// Fetch-side hazard controller: load-use stalls, EX branch redirects and data-memory freezes.
// Drives the PC-mux redirect value plus IF/ID and ID/EX pipeline-register controls.
module hazard_pc_controller #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT       = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_if,
  input  logic [4:0]  ifid_rs,
  input  logic [4:0]  ifid_rt,
  input  logic        ifid_uses_rt,
  input  logic        idex_memread,
  input  logic [4:0]  idex_rt,
  input  logic        branch_taken_ex,
  input  logic [31:0] branch_target_ex,
  input  logic        mem_busy,
  output logic [31:0] HAZARDPC,
  output logic        HazardMuxSelect,
  output logic        IfIdWrite,
  output logic        IfIdFlush,
  output logic        IdExBubble,
  output logic        PipeFreeze,
  output logic        mem_timeout
);

  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

  localparam logic [3:0]  LSC_M1    = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_W = 16'(MEM_TIMEOUT);
  localparam logic        MULTI_LSC = (LOAD_STALL_CYCLES > 1);

  state_t      state_reg, state_next;
  logic [31:0] hold_pc_reg, hold_pc_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [15:0] wait_cnt_reg, wait_cnt_next;
  logic        from_lu_reg, from_lu_next;
  logic        timeout_reg, timeout_next;

  logic        lu;
  logic        timeout_hit;
  logic [31:0] pc_sel;
  logic        sel_c, write_c, flush_c, bubble_c, freeze_c;

  assign lu = idex_memread && (idex_rt != 5'd0) &&
              ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

  assign timeout_hit = (state_reg == MEM_WAIT) && (wait_cnt_reg == TIMEOUT_W);

  always_comb begin
    state_next    = state_reg;
    hold_pc_next  = hold_pc_reg;
    cnt_next      = cnt_reg;
    wait_cnt_next = wait_cnt_reg;
    from_lu_next  = from_lu_reg;
    timeout_next  = timeout_reg | timeout_hit;
    pc_sel        = pc_if;
    sel_c         = 1'b0;
    write_c       = 1'b1;
    flush_c       = 1'b0;
    bubble_c      = 1'b0;
    freeze_c      = 1'b0;

    case (state_reg)
      RUN: begin
        if (mem_busy) begin
          freeze_c      = 1'b1;
          sel_c         = 1'b1;
          write_c       = 1'b0;
          hold_pc_next  = pc_if;
          wait_cnt_next = 16'd1;
          from_lu_next  = 1'b0;
          state_next    = MEM_WAIT;
        end else if (branch_taken_ex) begin
          sel_c    = 1'b1;
          pc_sel   = branch_target_ex;
          flush_c  = 1'b1;
          bubble_c = 1'b1;
        end else if (lu) begin
          sel_c        = 1'b1;
          write_c      = 1'b0;
          bubble_c     = 1'b1;
          hold_pc_next = pc_if;
          cnt_next     = LSC_M1;
          state_next   = MULTI_LSC ? LU_STALL : RUN;
        end
      end

      LU_STALL: begin
        if (mem_busy) begin
          // cnt is kept so the stall resumes with the right number of bubbles
          freeze_c      = 1'b1;
          sel_c         = 1'b1;
          write_c       = 1'b0;
          pc_sel        = hold_pc_reg;
          wait_cnt_next = 16'd1;
          from_lu_next  = 1'b1;
          state_next    = MEM_WAIT;
        end else if (branch_taken_ex) begin
          sel_c      = 1'b1;
          pc_sel     = branch_target_ex;
          flush_c    = 1'b1;
          bubble_c   = 1'b1;
          state_next = RUN;
        end else begin
          sel_c    = 1'b1;
          pc_sel   = hold_pc_reg;
          write_c  = 1'b0;
          bubble_c = 1'b1;
          if (cnt_reg == 4'd1) state_next = RUN;
          else                 cnt_next   = cnt_reg - 4'd1;
        end
      end

      MEM_WAIT: begin
        if (mem_busy) begin
          freeze_c      = 1'b1;
          sel_c         = 1'b1;
          write_c       = 1'b0;
          pc_sel        = hold_pc_reg;
          wait_cnt_next = (wait_cnt_reg == 16'hFFFF) ? wait_cnt_reg : wait_cnt_reg + 16'd1;
        end else if (branch_taken_ex) begin
          sel_c      = 1'b1;
          pc_sel     = branch_target_ex;
          flush_c    = 1'b1;
          bubble_c   = 1'b1;
          state_next = RUN;
        end else if (from_lu_reg) begin
          // This cycle is one bubble of the interrupted load-use stall
          sel_c    = 1'b1;
          pc_sel   = hold_pc_reg;
          write_c  = 1'b0;
          bubble_c = 1'b1;
          if (cnt_reg > 4'd1) begin
            cnt_next   = cnt_reg - 4'd1;
            state_next = LU_STALL;
          end else begin
            state_next = RUN;
          end
        end else if (lu) begin
          sel_c      = 1'b1;
          pc_sel     = hold_pc_reg;
          write_c    = 1'b0;
          bubble_c   = 1'b1;
          cnt_next   = LSC_M1;
          state_next = MULTI_LSC ? LU_STALL : RUN;
        end else begin
          state_next = RUN;
        end
      end

      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= RUN;
      hold_pc_reg  <= 32'd0;
      cnt_reg      <= 4'd0;
      wait_cnt_reg <= 16'd0;
      from_lu_reg  <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hold_pc_reg  <= hold_pc_next;
      cnt_reg      <= cnt_next;
      wait_cnt_reg <= wait_cnt_next;
      from_lu_reg  <= from_lu_next;
      timeout_reg  <= timeout_next;
    end
  end

  assign HAZARDPC        = rst ? 32'd0 : pc_sel;
  assign HazardMuxSelect = !rst && sel_c;
  assign IfIdWrite       = rst || write_c;
  assign IfIdFlush       = !rst && flush_c;
  assign IdExBubble      = !rst && bubble_c;
  assign PipeFreeze      = !rst && freeze_c;
  assign mem_timeout     = !rst && (timeout_reg || timeout_hit);

endmodule

// File: tb/tb_hazard_pc_controller.sv
// Scoreboard bench: two controllers (1-cycle and 3-cycle load-use stall) share one stimulus stream.
// Expected output vectors are queued per cycle; a negedge monitor pops and compares them.
module tb_hazard_pc_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_if;
  logic [4:0]  ifid_rs, ifid_rt, idex_rt;
  logic        ifid_uses_rt, idex_memread, branch_taken_ex, mem_busy;
  logic [31:0] branch_target_ex;

  logic [31:0] hpc_a, hpc_b;
  logic        sel_a, wr_a, fl_a, bu_a, fz_a, to_a;
  logic        sel_b, wr_b, fl_b, bu_b, fz_b, to_b;

  typedef struct packed {
    logic [31:0] pc;
    logic        sel;
    logic        wr;
    logic        flush;
    logic        bubble;
    logic        freeze;
    logic        tmo;
  } out_t;

  typedef struct {
    string name;
    out_t  a;
    out_t  b;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  hazard_pc_controller #(.LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(4)) u_a (
    .clk(clk), .rst(rst), .pc_if(pc_if), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_uses_rt(ifid_uses_rt), .idex_memread(idex_memread), .idex_rt(idex_rt),
    .branch_taken_ex(branch_taken_ex), .branch_target_ex(branch_target_ex),
    .mem_busy(mem_busy), .HAZARDPC(hpc_a), .HazardMuxSelect(sel_a), .IfIdWrite(wr_a),
    .IfIdFlush(fl_a), .IdExBubble(bu_a), .PipeFreeze(fz_a), .mem_timeout(to_a)
  );

  hazard_pc_controller #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(4)) u_b (
    .clk(clk), .rst(rst), .pc_if(pc_if), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_uses_rt(ifid_uses_rt), .idex_memread(idex_memread), .idex_rt(idex_rt),
    .branch_taken_ex(branch_taken_ex), .branch_target_ex(branch_target_ex),
    .mem_busy(mem_busy), .HAZARDPC(hpc_b), .HazardMuxSelect(sel_b), .IfIdWrite(wr_b),
    .IfIdFlush(fl_b), .IdExBubble(bu_b), .PipeFreeze(fz_b), .mem_timeout(to_b)
  );

  function automatic out_t mk(input logic [31:0] pc, input logic s, input logic w,
                              input logic f, input logic bb, input logic fz, input logic t);
    out_t o;
    o.pc = pc; o.sel = s; o.wr = w; o.flush = f; o.bubble = bb; o.freeze = fz; o.tmo = t;
    return o;
  endfunction

  function automatic out_t inact(input logic [31:0] pc); return mk(pc, 0, 1, 0, 0, 0, 0); endfunction
  function automatic out_t stall(input logic [31:0] pc); return mk(pc, 1, 0, 0, 1, 0, 0); endfunction
  function automatic out_t redir(input logic [31:0] pc); return mk(pc, 1, 1, 1, 1, 0, 0); endfunction
  function automatic out_t frz(input logic [31:0] pc);   return mk(pc, 1, 0, 0, 0, 1, 0); endfunction
  function automatic out_t tmo(input out_t o);
    out_t r;
    r = o; r.tmo = 1'b1;
    return r;
  endfunction

  // One expectation per cycle; inputs are already applied when this is called
  task automatic cyc(input string n, input out_t ea, input out_t eb);
    exp_t e;
    e.name = n; e.a = ea; e.b = eb;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    pc_if = 32'd0; ifid_rs = 5'd0; ifid_rt = 5'd0; ifid_uses_rt = 1'b0;
    idex_memread = 1'b0; idex_rt = 5'd0; branch_taken_ex = 1'b0;
    branch_target_ex = 32'd0; mem_busy = 1'b0;
  endtask

  task automatic rst_cycle();
    clear_inputs();
    rst = 1'b1;
    cyc("reset", mk(0, 0, 1, 0, 0, 0, 0), mk(0, 0, 1, 0, 0, 0, 0));
    rst = 1'b0;
  endtask

  task automatic set_lu(input logic [31:0] pc);
    pc_if = pc; idex_memread = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      out_t act_a, act_b;
      e = q.pop_front();
      act_a = {hpc_a, sel_a, wr_a, fl_a, bu_a, fz_a, to_a};
      act_b = {hpc_b, sel_b, wr_b, fl_b, bu_b, fz_b, to_b};
      n_checks += 2;
      if (act_a === e.a) n_pass++;
      else $display("FAIL %s lsc1: got pc=%h sel/wr/fl/bu/fz/to=%b required pc=%h sel/wr/fl/bu/fz/to=%b",
                    e.name, act_a.pc, act_a[5:0], e.a.pc, e.a[5:0]);
      if (act_b === e.b) n_pass++;
      else $display("FAIL %s lsc3: got pc=%h sel/wr/fl/bu/fz/to=%b required pc=%h sel/wr/fl/bu/fz/to=%b",
                    e.name, act_b.pc, act_b[5:0], e.b.pc, e.b[5:0]);
      $display("chk %-12s lsc1 pc=%h %b  lsc3 pc=%h %b", e.name, act_a.pc, act_a[5:0], act_b.pc, act_b[5:0]);
    end
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset dominates a pending freeze and load-use
    mem_busy = 1'b1; set_lu(32'h40);
    cyc("rst_hold1", mk(0, 0, 1, 0, 0, 0, 0), mk(0, 0, 1, 0, 0, 0, 0));
    cyc("rst_hold2", mk(0, 0, 1, 0, 0, 0, 0), mk(0, 0, 1, 0, 0, 0, 0));
    rst = 1'b0;
    cyc("rst_release", frz(32'h40), frz(32'h40));
    rst_cycle();

    // Load-use: one bubble versus three bubbles held at the hazard PC
    set_lu(32'h40);
    cyc("lu_1", stall(32'h40), stall(32'h40));
    idex_memread = 1'b0; pc_if = 32'h44;
    cyc("lu_2", inact(32'h44), stall(32'h40));
    cyc("lu_3", inact(32'h44), stall(32'h40));
    cyc("lu_4", inact(32'h44), inact(32'h44));

    // Register 0 never hazards; rt only matters when used
    pc_if = 32'h50; idex_memread = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0;
    cyc("lu_r0", inact(32'h50), inact(32'h50));
    idex_rt = 5'd9; ifid_rs = 5'd8; ifid_rt = 5'd9; ifid_uses_rt = 1'b0;
    cyc("lu_rt_unused", inact(32'h50), inact(32'h50));
    ifid_uses_rt = 1'b1;
    cyc("lu_rt_used", stall(32'h50), stall(32'h50));
    idex_memread = 1'b0; ifid_uses_rt = 1'b0; pc_if = 32'h54;
    cyc("lu_rt_2", inact(32'h54), stall(32'h50));
    cyc("lu_rt_3", inact(32'h54), stall(32'h50));
    cyc("lu_rt_4", inact(32'h54), inact(32'h54));

    // Branch wins over load-use in the same cycle
    set_lu(32'h60); branch_taken_ex = 1'b1; branch_target_ex = 32'h100;
    cyc("br_vs_lu", redir(32'h100), redir(32'h100));
    branch_taken_ex = 1'b0; idex_memread = 1'b0; pc_if = 32'h100;
    cyc("br_after", inact(32'h100), inact(32'h100));

    // Branch abandons an in-progress stall
    set_lu(32'h70);
    cyc("lu_br_1", stall(32'h70), stall(32'h70));
    idex_memread = 1'b0; branch_taken_ex = 1'b1; branch_target_ex = 32'h300;
    cyc("lu_br_2", redir(32'h300), redir(32'h300));
    branch_taken_ex = 1'b0; pc_if = 32'h300;
    cyc("lu_br_3", inact(32'h300), inact(32'h300));
    rst_cycle();

    // Memory wait with timeout at the 4th MEM_WAIT cycle, then branch on release
    pc_if = 32'h80; mem_busy = 1'b1;
    cyc("mw_1", frz(32'h80), frz(32'h80));
    pc_if = 32'h84;
    cyc("mw_2", frz(32'h80), frz(32'h80));
    cyc("mw_3", frz(32'h80), frz(32'h80));
    cyc("mw_4", frz(32'h80), frz(32'h80));
    cyc("mw_5_tmo", tmo(frz(32'h80)), tmo(frz(32'h80)));
    mem_busy = 1'b0; branch_taken_ex = 1'b1; branch_target_ex = 32'h200;
    cyc("mw_release", tmo(redir(32'h200)), tmo(redir(32'h200)));
    branch_taken_ex = 1'b0; pc_if = 32'h200;
    cyc("tmo_sticky", tmo(inact(32'h200)), tmo(inact(32'h200)));
    rst_cycle();
    cyc("tmo_cleared", inact(32'h0), inact(32'h0));

    // Memory busy in the middle of a load-use stall
    set_lu(32'h90);
    cyc("lum_1", stall(32'h90), stall(32'h90));
    mem_busy = 1'b1; pc_if = 32'h94;
    cyc("lum_2", frz(32'h94), frz(32'h90));
    cyc("lum_3", frz(32'h94), frz(32'h90));
    mem_busy = 1'b0;
    cyc("lum_4", stall(32'h94), stall(32'h90));
    idex_memread = 1'b0;
    cyc("lum_5", inact(32'h94), stall(32'h90));
    cyc("lum_6", inact(32'h94), inact(32'h94));

    repeat (3) @(posedge clk);
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expectations, required 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
